kgp_control_fsm: RTL
====================

# kgp_control_fsm

Multi-cycle control sequencer for the KGP-RISC datapath. Owns the program counter, steps each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath control strobe from the latched opcode/funccode. Sits between the top level and `Datapath`: its `instrAddr` feeds the datapath, and it captures `nextInstrAddr` back into the PC.

## Interface
- `PC_W`, default 32: PC / instruction address width.
- `CNT_W`, default 32: retired-instruction counter width.

- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `run`  in  1: level enable; sampled only in S_FETCH.
- `opcode`  in  5: from datapath, valid from S_DECODE onward.
- `funccode`  in  5: from datapath, valid from S_DECODE onward.
- `nextInstrAddr`  in  PC_W: from datapath NextInstr.
- `instrAddr`  out  PC_W: PC register.
- `ALUResOp`, `branch`  out  3 each: ALU function and branch type.
- `ALUSrc`  out  2: 00 register, 01 sign-extended immediate, 10 shamt.
- `ALUCin`, `ALUDir`, `ALUFrc`, `brLink`, `memToReg`, `memRead`, `memWrite`, `regWrite`  out  1 each.
- `halted`  out  1: high in S_HALT.
- `illegalOp`  out  1: sticky, set on an unknown opcode/funccode.
- `retired`  out  CNT_W: count of completed instructions, wraps.

## Operation
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT.
- S_FETCH: hold `instrAddr`. Go to S_DECODE if `run`=1, else stay.
- S_DECODE: latch `opcode` and `funccode` into internal registers. All later control derives from these latched copies.
- Opcode map: 00000 ALU-R, 00001 ADDI, 00010 COMPI, 00011 LW, 00100 SW, 00101 BR (register jump), 00110 BRANCH (funccode[2:0] = type), 11111 HALT.
- ALU-R funccode: 00000 add, 00001 comp, 00010 and, 00011 xor, 00100 shll, 00101 shrl, 00110 shllv, 00111 shrlv, 01000 shra, 01001 shrav.
- ALUResOp: ADD=000, AND=001, XOR=010, SHL=011, SHRA=100.
  - comp / compi: ADD with `ALUCin`=1.
  - `ALUDir`: 0 = left, 1 = right.
  - Shifts by immediate use `ALUSrc`=10; variable shifts use 00.
- LW/SW: ADD, `ALUSrc`=01, `ALUFrc`=1.
- Transitions:
  - ALU-R, ADDI, COMPI: DECODE → EXEC → WB.
  - LW: EXEC → MEM → WB.
  - SW: EXEC → MEM.
  - BR, BRANCH: EXEC → WB.
  - HALT: DECODE → S_HALT.
- Strobes:
  - `regWrite` is high only in S_WB: for ALU/ADDI/COMPI/LW, and for BRANCH when `brLink`=1 (bl).
  - `memRead` is high in S_MEM for LW. `memWrite` is high only in S_MEM for SW.
  - `memToReg`=1 for LW in MEM and WB; otherwise 0.
  - `branch` ≠ 000 only for BR/BRANCH, from S_EXEC through the final state.
- Retire cycle = the last state of each instruction (WB, or MEM for SW). In that cycle: PC ← `nextInstrAddr`, `retired`++, next state is S_FETCH.
- Unknown opcode/funccode: executes as a NOP (EXEC → WB, no strobes, `branch`=000), and sets `illegalOp`.
- S_HALT is absorbing; only `rst` exits it. `halted`=1 there.

## Timing
- Reset (async assert, sync release): state S_FETCH, PC=0, `retired`=0, `illegalOp`=0. All strobes, `ALUResOp`, `ALUSrc` and `branch` are 0.
- Control outputs are a Moore decode of state plus latched opcode. They are glitch-free, each held for one full cycle.
- Instruction memory read latency is 1 cycle: opcode is valid in S_DECODE.
- Data memory is clocked on the falling edge: one S_MEM cycle completes a read or write.
- Cycles per instruction: ALU/ADDI/COMPI/BR/BRANCH 4, LW 5, SW 4, HALT 2 (to S_HALT).
- PC changes only on the retire-cycle rising edge.
- `run` deasserted mid-instruction has no effect; it blocks only the next fetch.
- `rst` asserted mid-instruction aborts immediately; no partial write-back occurs after the reset edge.

## Structure
- Package `kgp_pkg`: opcode constants, ALU funccode constants, ALUResOp codes, branch-type codes, ALUSrc codes, state enum.
- Sub-module `kgp_decoder`: combinational mapping from {state, latched opcode, latched funccode} to the control bundle plus an illegal flag. The FSM, PC, counter and latches stay in `kgp_control_fsm`.

## Test plan
- Reset then `run`=1, ALU-R add (funccode 00000): states F, D, E, WB. `regWrite`=1 only in cycle 4; PC 0→nextInstrAddr; `retired`=1.
- LW: MEM state with `memRead`=1, `memToReg`=1, `ALUFrc`=1, `ALUSrc`=01. `regWrite` in cycle 5 only; 5-cycle latency.
- SW: `memWrite`=1 for exactly one cycle (cycle 4), `regWrite` never asserted; next fetch on cycle 5.
- BRANCH bl (funccode[2:0] = bl code): `brLink`=1 and `regWrite`=1 in WB; PC ← `nextInstrAddr`=0x40.
- Opcode 11111: `halted`=1 from cycle 3 and stays. PC frozen, `retired` unchanged despite `run`=1; `rst` low restores PC=0, S_FETCH.
- Opcode 01111: NOP, `illegalOp`=1 sticky; `run`=0 in S_FETCH stalls indefinitely with all strobes 0.

Source files
------------

// File: rtl/kgp_pkg.sv
// kgp_pkg: shared encodings for the KGP-RISC control sequencer.
//   Opcode / ALU funccode constants, ALUResOp codes, ALUSrc codes,
//   branch-type output codes, BRANCH funccode[2:0] subtypes, the
//   control-bundle struct and the sequencer state enum.
package kgp_pkg;

  // Opcodes
  localparam logic [4:0] OP_ALUR   = 5'b00000;
  localparam logic [4:0] OP_ADDI   = 5'b00001;
  localparam logic [4:0] OP_COMPI  = 5'b00010;
  localparam logic [4:0] OP_LW     = 5'b00011;
  localparam logic [4:0] OP_SW     = 5'b00100;
  localparam logic [4:0] OP_BR     = 5'b00101;
  localparam logic [4:0] OP_BRANCH = 5'b00110;
  localparam logic [4:0] OP_HALT   = 5'b11111;

  // ALU-R funccodes
  localparam logic [4:0] FN_ADD   = 5'b00000;
  localparam logic [4:0] FN_COMP  = 5'b00001;
  localparam logic [4:0] FN_AND   = 5'b00010;
  localparam logic [4:0] FN_XOR   = 5'b00011;
  localparam logic [4:0] FN_SHLL  = 5'b00100;
  localparam logic [4:0] FN_SHRL  = 5'b00101;
  localparam logic [4:0] FN_SHLLV = 5'b00110;
  localparam logic [4:0] FN_SHRLV = 5'b00111;
  localparam logic [4:0] FN_SHRA  = 5'b01000;
  localparam logic [4:0] FN_SHRAV = 5'b01001;

  // ALUResOp codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SHL  = 3'b011;
  localparam logic [2:0] ALU_SHRA = 3'b100;

  // ALUSrc codes
  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;
  localparam logic [1:0] SRC_SHAMT = 2'b10;

  // Branch-type output codes (000 means no branch)
  localparam logic [2:0] BRT_NONE = 3'b000;
  localparam logic [2:0] BRT_REG  = 3'b001;
  localparam logic [2:0] BRT_B    = 3'b010;
  localparam logic [2:0] BRT_BL   = 3'b011;
  localparam logic [2:0] BRT_BZ   = 3'b100;
  localparam logic [2:0] BRT_BNZ  = 3'b101;
  localparam logic [2:0] BRT_BCY  = 3'b110;
  localparam logic [2:0] BRT_BNCY = 3'b111;

  // BRANCH subtypes carried in funccode[2:0]; 110/111 are unassigned
  localparam logic [2:0] BF_B    = 3'b000;
  localparam logic [2:0] BF_BL   = 3'b001;
  localparam logic [2:0] BF_BZ   = 3'b010;
  localparam logic [2:0] BF_BNZ  = 3'b011;
  localparam logic [2:0] BF_BCY  = 3'b100;
  localparam logic [2:0] BF_BNCY = 3'b101;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] aluResOp;
    logic [1:0] aluSrc;
    logic       aluCin;
    logic       aluDir;
    logic       aluFrc;
    logic [2:0] branch;
    logic       brLink;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
  } ctrl_t;

endpackage

// File: rtl/kgp_decoder.sv
// kgp_decoder: combinational control decode.
//   state    in  : current sequencer state
//   opcode   in 5: latched opcode
//   funccode in 5: latched funccode
//   ctrl     out : control bundle, zero outside EXEC/MEM/WB
//   illegal  out : opcode/funccode combination is unassigned
module kgp_decoder
  import kgp_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic [4:0] funccode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  logic [2:0] exOp;
  logic [1:0] exSrc;
  logic       exCin;
  logic       exDir;
  logic       exFrc;
  logic [2:0] exBr;
  logic       exLnk;
  logic       isLoad;
  logic       isStore;
  logic       writesReg;

  // Per-instruction controls, independent of state.
  always_comb begin
    exOp      = ALU_ADD;
    exSrc     = SRC_REG;
    exCin     = 1'b0;
    exDir     = 1'b0;
    exFrc     = 1'b0;
    exBr      = BRT_NONE;
    exLnk     = 1'b0;
    isLoad    = 1'b0;
    isStore   = 1'b0;
    writesReg = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_ALUR: begin
        writesReg = 1'b1;
        case (funccode)
          FN_ADD:   ;
          FN_COMP:  exCin = 1'b1;
          FN_AND:   exOp = ALU_AND;
          FN_XOR:   exOp = ALU_XOR;
          FN_SHLL:  begin exOp = ALU_SHL;  exSrc = SRC_SHAMT; end
          FN_SHRL:  begin exOp = ALU_SHL;  exSrc = SRC_SHAMT; exDir = 1'b1; end
          FN_SHLLV: exOp = ALU_SHL;
          FN_SHRLV: begin exOp = ALU_SHL;  exDir = 1'b1; end
          FN_SHRA:  begin exOp = ALU_SHRA; exSrc = SRC_SHAMT; exDir = 1'b1; end
          FN_SHRAV: begin exOp = ALU_SHRA; exDir = 1'b1; end
          default: begin
            writesReg = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        exSrc     = SRC_IMM;
        writesReg = 1'b1;
      end
      OP_COMPI: begin
        exSrc     = SRC_IMM;
        exCin     = 1'b1;
        writesReg = 1'b1;
      end
      OP_LW: begin
        exSrc     = SRC_IMM;
        exFrc     = 1'b1;
        isLoad    = 1'b1;
        writesReg = 1'b1;
      end
      OP_SW: begin
        exSrc   = SRC_IMM;
        exFrc   = 1'b1;
        isStore = 1'b1;
      end
      OP_BR: exBr = BRT_REG;
      OP_BRANCH: begin
        case (funccode[2:0])
          BF_B:    exBr = BRT_B;
          BF_BL:   begin exBr = BRT_BL; exLnk = 1'b1; writesReg = 1'b1; end
          BF_BZ:   exBr = BRT_BZ;
          BF_BNZ:  exBr = BRT_BNZ;
          BF_BCY:  exBr = BRT_BCY;
          BF_BNCY: exBr = BRT_BNCY;
          default: illegal = 1'b1;
        endcase
      end
      OP_HALT: ;
      default: illegal = 1'b1;
    endcase
  end

  // Gate by state so the latched opcode of the previous instruction
  // never leaks into FETCH/DECODE.
  always_comb begin
    ctrl = '0;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      ctrl.aluResOp = exOp;
      ctrl.aluSrc   = exSrc;
      ctrl.aluCin   = exCin;
      ctrl.aluDir   = exDir;
      ctrl.aluFrc   = exFrc;
      ctrl.branch   = exBr;
      ctrl.brLink   = exLnk;
    end
    ctrl.memRead  = (state == S_MEM) && isLoad;
    ctrl.memWrite = (state == S_MEM) && isStore;
    ctrl.memToReg = isLoad && (state == S_MEM || state == S_WB);
    ctrl.regWrite = (state == S_WB) && writesReg;
  end

endmodule

// File: rtl/kgp_control_fsm.sv
// kgp_control_fsm: multi-cycle KGP-RISC control sequencer.
//   clk, rst (async, active low), run (sampled in FETCH)
//   opcode/funccode in : from datapath, latched in DECODE
//   nextInstrAddr   in : captured into the PC on the retire cycle
//   instrAddr       out: PC register
//   ALU*/branch/brLink/mem*/regWrite out: Moore control strobes
//   halted, illegalOp (sticky), retired (wrapping count) out
module kgp_control_fsm
  import kgp_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic [4:0]       funccode,
  input  logic [PC_W-1:0]  nextInstrAddr,
  output logic [PC_W-1:0]  instrAddr,
  output logic [2:0]       ALUResOp,
  output logic [2:0]       branch,
  output logic [1:0]       ALUSrc,
  output logic             ALUCin,
  output logic             ALUDir,
  output logic             ALUFrc,
  output logic             brLink,
  output logic             memToReg,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic             halted,
  output logic             illegalOp,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     nextState;
  logic [4:0] opLatch;
  logic [4:0] fnLatch;
  logic       retire;
  logic       memOp;
  logic       decIllegal;
  ctrl_t      ctrl;

  kgp_decoder uDecoder (
    .state    (state),
    .opcode   (opLatch),
    .funccode (fnLatch),
    .ctrl     (ctrl),
    .illegal  (decIllegal)
  );

  assign memOp = (opLatch == OP_LW) || (opLatch == OP_SW);

  // The DECODE exit looks at the live opcode: the latch is only loaded
  // on that same edge.
  always_comb begin
    nextState = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (run) nextState = S_DECODE;
      S_DECODE: nextState = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   nextState = memOp ? S_MEM : S_WB;
      S_MEM: begin
        if (opLatch == OP_SW) begin
          nextState = S_FETCH;
          retire    = 1'b1;
        end else begin
          nextState = S_WB;
        end
      end
      S_WB: begin
        nextState = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT:   nextState = S_HALT;
      default:  nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      opLatch   <= '0;
      fnLatch   <= '0;
      instrAddr <= '0;
      retired   <= '0;
      illegalOp <= 1'b0;
    end else begin
      state <= nextState;
      if (state == S_DECODE) begin
        opLatch <= opcode;
        fnLatch <= funccode;
      end
      if (retire) begin
        instrAddr <= nextInstrAddr;
        retired   <= retired + CNT_W'(1);
      end
      if (state == S_EXEC && decIllegal) illegalOp <= 1'b1;
    end
  end

  assign ALUResOp = ctrl.aluResOp;
  assign ALUSrc   = ctrl.aluSrc;
  assign ALUCin   = ctrl.aluCin;
  assign ALUDir   = ctrl.aluDir;
  assign ALUFrc   = ctrl.aluFrc;
  assign branch   = ctrl.branch;
  assign brLink   = ctrl.brLink;
  assign memToReg = ctrl.memToReg;
  assign memRead  = ctrl.memRead;
  assign memWrite = ctrl.memWrite;
  assign regWrite = ctrl.regWrite;
  assign halted   = (state == S_HALT);

endmodule
